instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Responder end of the instruction fetch bus (req/gnt/rvalid protocol) driven by the prefetch buffer. Models a word-addressed instruction memory with fixed, parameterised response latency, a bounded number of in-flight transactions, injectable grant stalls and an out-of-range error response. It sits on the memory side of `instr_req_o`/`instr_gnt_i`/`instr_rvalid_i` in test harnesses and FPGA builds. A side load port preloads program images.

## Interface
- `MemWords`, 1024: memory depth in 32-bit words; power of two, at least 2.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to `4*MemWords`.
- `Latency`, 1: cycles from grant edge to `instr_rvalid_o`; legal range 1..4.
- `MaxOutstanding`, 2: maximum granted-but-unanswered requests; legal range 1..4.

Ports:
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `instr_req_i`  in  1  fetch request; held by the initiator until granted.
- `instr_addr_i`  in  32  byte address; bits [1:0] are ignored.
- `instr_gnt_o`  out  1  grant; combinational from this cycle's inputs and state.
- `instr_rvalid_o`  out  1  response valid, one cycle per granted request.
- `instr_rdata_o`  out  32  response data; 0 when `instr_err_o` is high or `instr_rvalid_o` is low.
- `instr_err_o`  out  1  response error (address out of range); qualified by `instr_rvalid_o`.
- `gnt_stall_i`  in  1  forces `instr_gnt_o` low while high.
- `load_we_i`  in  1  memory write strobe for preload.
- `load_addr_i`  in  $clog2(MemWords)  word index for the write.
- `load_wdata_i`  in  32  write data.
- `busy_o`  out  1  high while the in-flight count is nonzero.

## Operation
- **Slot check.** `slot_free = (inflight_q < MaxOutstanding) | instr_rvalid_o`. A response retiring in the current cycle frees its slot in that same cycle.
- **Grant.** `instr_gnt_o = instr_req_i & ~gnt_stall_i & slot_free & ~rst_i`. A grant accepts the address present in that cycle.
- **Range check.** The address is in range when `BaseAddr <= addr < BaseAddr + 4*MemWords`.
  - In range: word index = `(addr - BaseAddr) >> 2`.
  - Out of range: no memory read occurs; the response carries err=1 and rdata=0.
- **Memory read.** The memory is read synchronously at the grant edge.
  - If a load write hits the same word at the same edge, the read returns the old data (read-before-write).
- **Response pipeline.** A shift pipeline `Latency` deep carries {valid, err, data}.
  - Stage 0 is loaded at the grant edge.
  - The final stage drives `instr_rvalid_o`, `instr_rdata_o` and `instr_err_o`.
  - Responses return strictly in grant order.
  - There is no response backpressure; the protocol has no rready.
- **In-flight counter.** `inflight_q` is `$clog2(MaxOutstanding+1)` bits wide.
  - Next value = `inflight_q + gnt - rvalid`.
  - A grant and a response in the same cycle leave it unchanged.
  - It never exceeds `MaxOutstanding` and never underflows.
- **Effective concurrency.** Concurrency is `min(Latency, MaxOutstanding)`. With `MaxOutstanding < Latency`, grants are throttled, giving sustained throughput of `MaxOutstanding/Latency`.
- **Load port.** Writes may occur at any time, including during fetches. `load_addr_i` indexes words directly and is not offset by `BaseAddr`.
- **Memory contents.** They are not reset and are retained across `rst_i`.

## Timing
- **Reset.** While `rst_i` is high at an edge, the next cycle has:
  - `instr_rvalid_o`=0, `instr_err_o`=0, `instr_rdata_o`=0;
  - `busy_o`=0, `inflight_q`=0;
  - all pipeline valids cleared.
  
  `instr_gnt_o` is 0 in any cycle where `rst_i`=1.
- **Reset mid-operation.** In-flight responses are dropped and never delivered. The first grant is possible in the first cycle after `rst_i` falls.
- **Latency.** A grant in cycle N produces rvalid in cycle N+`Latency`.
- **Back-to-back.** With `Latency`=1 and `MaxOutstanding`>=1, one grant and one rvalid per cycle are sustainable indefinitely.
- **Stall.** `gnt_stall_i` affects only new grants. Already-granted requests still respond on schedule.
- **Full condition.** When `inflight_q`==`MaxOutstanding` and no rvalid occurs this cycle, gnt=0 even with req=1. The initiator holds req and addr.
- **Response stability.** `instr_rdata_o`/`instr_err_o` are 0 in cycles with rvalid=0, so the bench can check them unconditionally.

## Test plan
- **Preload and single fetch.** Preload word 5 = 32'hDEAD_BEEF, `Latency`=1, addr=32'h14 (also repeat with addr=32'h17) → gnt same cycle, rvalid next cycle with rdata=32'hDEAD_BEEF, err=0, `busy_o` high for exactly 1 cycle.
- **Throttling.** `Latency`=3, `MaxOutstanding`=2, req held high on consecutive addresses 0,4,8 → grants in cycles 0,1,3, rvalids in cycles 3,4,6 returned in order; gnt=0 in cycle 2.
- **Out-of-range error.** `BaseAddr`=32'h1000, `MemWords`=1024, fetch 32'h0FFC and 32'h2000 → both responses have err=1 and rdata=0. Fetch 32'h1FFC → err=0 with word 1023's data.
- **Grant stall and simultaneous grant/retire.** Assert `gnt_stall_i` for 4 cycles with req high → no grant, `busy_o`=0. On release, the grant occurs the same cycle. Also, with `MaxOutstanding`=1 and `Latency`=1, continuous req → gnt every cycle because the retiring slot frees in the same cycle.
- **Reset mid-flight.** `Latency`=4, two requests granted, then `rst_i` pulsed for 1 cycle → no rvalid ever appears for them, `busy_o`=0 after reset, and preloaded data is still readable afterwards.
- **Load/read collision.** Word 2 = A; in the same cycle, grant addr 32'h8 and load word 2 = B → the response returns A, and the next fetch of 32'h8 returns B.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus (req/gnt/rvalid protocol).
//   req    : fetch request, held by the initiator until granted
//   addr   : byte address of the fetch (bits [1:0] ignored by the responder)
//   gnt    : grant, accepts addr in the same cycle
//   rvalid : one response cycle per granted request, in grant order
//   rdata  : response data, zero unless rvalid is high and err is low
//   err    : response error, qualified by rvalid
// master = prefetch side, slave = memory side.
interface instr_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/instr_mem_responder.sv
// Word-addressed instruction memory answering the fetch bus with a fixed
// response latency, a bounded number of in-flight requests, injectable grant
// stalls and an error response for addresses outside the memory window.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset (memory contents are kept)
//   bus        : fetch bus, slave side
//   gnt_stall  : blocks new grants while high
//   load_we    : preload write strobe
//   load_addr  : preload word index (not offset by BaseAddr)
//   load_wdata : preload data
//   busy       : high while any granted request is still unanswered
module instr_mem_responder #(
  parameter int          MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 2,
  localparam int         AddrW          = $clog2(MemWords)
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_mem_responder_if.slave    bus,
  input  logic                    gnt_stall,
  input  logic                    load_we,
  input  logic [AddrW-1:0]        load_addr,
  input  logic [31:0]             load_wdata,
  output logic                    busy
);

  localparam int          CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] MemSpan = 33'(MemWords) << 2;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0]      mem [MemWords];
  resp_t            stage [Latency];
  logic [CntW-1:0]  inflight_q;

  logic             slot_free;
  logic             gnt;
  logic [32:0]      offset;
  logic             in_range;
  logic [AddrW-1:0] word_idx;

  // A response leaving the pipeline this cycle frees its slot right away,
  // so a full responder can still grant in the retiring cycle.
  assign slot_free = (inflight_q < CntW'(MaxOutstanding)) | bus.rvalid;
  assign gnt       = bus.req & ~gnt_stall & slot_free & ~rst;

  // 33-bit arithmetic keeps the upper window bound from wrapping.
  assign offset   = {1'b0, bus.addr} - {1'b0, BaseAddr};
  assign in_range = (bus.addr >= BaseAddr) && (offset < MemSpan);
  assign word_idx = offset[AddrW+1:2];

  assign bus.gnt    = gnt;
  assign bus.rvalid = stage[Latency-1].valid;
  assign bus.err    = stage[Latency-1].err;
  assign bus.rdata  = stage[Latency-1].data;
  assign busy       = (inflight_q != '0);

  // Memory array is never reset; a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_wdata;
    end
  end

  // Invalid stages always carry zero err/data, so the outputs are clean
  // without extra gating on the final stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Latency; i++) begin
        stage[i] <= '0;
      end
      inflight_q <= '0;
    end else begin
      stage[0].valid <= gnt;
      stage[0].err   <= gnt & ~in_range;
      stage[0].data  <= (gnt & in_range) ? mem[word_idx] : 32'h0;
      for (int i = 1; i < Latency; i++) begin
        stage[i] <= stage[i-1];
      end
      inflight_q <= inflight_q + CntW'(gnt) - CntW'(bus.rvalid);
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: three responders with different parameter sets share
// one stimulus stream. A transaction-level model (queue of pending responses
// with due cycles plus a word array) checks every output of every instance
// each cycle; table vectors and short sequences pin the corner cases.
module tb_instr_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;
  logic        busy0, busy1, busy2;

  instr_mem_responder_if bus0 ();
  instr_mem_responder_if bus1 ();
  instr_mem_responder_if bus2 ();

  assign bus0.req = req;  assign bus0.addr = addr;
  assign bus1.req = req;  assign bus1.addr = addr;
  assign bus2.req = req;  assign bus2.addr = addr;

  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus0), .gnt_stall(stall), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(busy0));
  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h1000), .Latency(3), .MaxOutstanding(2)) u_lat3 (
    .clk(clk), .rst(rst), .bus(bus1), .gnt_stall(stall), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(busy1));
  instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(4), .MaxOutstanding(2)) u_lat4 (
    .clk(clk), .rst(rst), .bus(bus2), .gnt_stall(stall), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(busy2));

  logic        d_gnt [3];
  logic        d_rv  [3];
  logic [31:0] d_rd  [3];
  logic        d_err [3];
  logic        d_busy[3];
  assign d_gnt[0] = bus0.gnt;  assign d_rv[0] = bus0.rvalid;  assign d_rd[0] = bus0.rdata;
  assign d_err[0] = bus0.err;  assign d_busy[0] = busy0;
  assign d_gnt[1] = bus1.gnt;  assign d_rv[1] = bus1.rvalid;  assign d_rd[1] = bus1.rdata;
  assign d_err[1] = bus1.err;  assign d_busy[1] = busy1;
  assign d_gnt[2] = bus2.gnt;  assign d_rv[2] = bus2.rvalid;  assign d_rd[2] = bus2.rdata;
  assign d_err[2] = bus2.err;  assign d_busy[2] = busy2;

  int          m_lat [3] = '{1, 3, 4};
  int          m_max [3] = '{1, 2, 2};
  logic [31:0] m_base[3] = '{32'h0, 32'h1000, 32'h0};

  typedef struct {
    int          k;
    int          due;
    logic        err;
    logic [31:0] data;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] mem_m [1024];
  int          cyc;
  int          total;
  int          bad;

  logic        s_gnt [3];
  logic        s_rv  [3];
  logic [31:0] s_rd  [3];
  logic        s_err [3];
  logic        s_busy[3];

  logic        g_hist[16];
  logic        v_hist[16];
  logic [31:0] rsp_d[$];
  logic        rsp_e[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare all instances against the model, then advance it.
  task automatic tick();
    logic eg[3];
    #1;
    for (int k = 0; k < 3; k++) begin
      int   idx;
      int   cnt;
      logic ret;
      idx = -1;
      cnt = 0;
      for (int i = 0; i < pq.size(); i++) begin
        if (pq[i].k == k) begin
          if (idx < 0) idx = i;
          cnt++;
        end
      end
      ret = (idx >= 0) && (pq[idx].due == cyc);
      s_gnt[k] = d_gnt[k];  s_rv[k] = d_rv[k];  s_rd[k] = d_rd[k];
      s_err[k] = d_err[k];  s_busy[k] = d_busy[k];
      eg[k] = req & ~stall & ~rst & ((cnt < m_max[k]) || ret);
      chk($sformatf("m%0d_gnt", k), {31'b0, d_gnt[k]}, {31'b0, eg[k]});
      chk($sformatf("m%0d_rvalid", k), {31'b0, d_rv[k]}, {31'b0, ret});
      chk($sformatf("m%0d_rdata", k), d_rd[k], ret ? pq[idx].data : 32'h0);
      chk($sformatf("m%0d_err", k), {31'b0, d_err[k]}, {31'b0, ret ? pq[idx].err : 1'b0});
      chk($sformatf("m%0d_busy", k), {31'b0, d_busy[k]}, {31'b0, cnt != 0});
    end
    @(posedge clk);
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (rst || pq[i].due == cyc) pq.delete(i);
    end
    for (int k = 0; k < 3; k++) begin
      if (eg[k]) begin
        pend_t       p;
        logic [32:0] off;
        logic        inr;
        off = {1'b0, addr} - {1'b0, m_base[k]};
        inr = (addr >= m_base[k]) && (off < 33'd4096);
        p.k    = k;
        p.due  = cyc + m_lat[k];
        p.err  = ~inr;
        p.data = inr ? mem_m[off[11:2]] : 32'h0;
        pq.push_back(p);
      end
    end
    if (load_we) mem_m[load_addr] = load_wdata;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 0; stall = 0; load_we = 0; rst = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present up to three addresses in order, holding each until granted by
  // instance k; record k's grant/rvalid history and its responses.
  task automatic fetch_list(input int k, input int n, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] a2, input int ncyc);
    logic [31:0] al[3];
    int          p;
    al[0] = a0; al[1] = a1; al[2] = a2;
    p = 0;
    rsp_d.delete();
    rsp_e.delete();
    for (int c = 0; c < ncyc; c++) begin
      req  = (p < n);
      addr = 32'h0;
      if (p < n) addr = al[p];
      tick();
      g_hist[c] = s_gnt[k];
      v_hist[c] = s_rv[k];
      if (s_gnt[k]) p++;
      if (s_rv[k]) begin
        rsp_d.push_back(s_rd[k]);
        rsp_e.push_back(s_err[k]);
      end
    end
    req = 0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        rst;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vt[16];

  initial begin
    total = 0; bad = 0; cyc = 0;
    req = 0; addr = 0; stall = 0; load_we = 0; load_addr = 0; load_wdata = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state, still in reset
    tick();
    rst = 0;

    // preload every word so the model always knows the contents
    for (int i = 0; i < 1024; i++) begin
      load_we = 1; load_addr = 10'(i); load_wdata = $urandom;
      tick();
    end
    load_we = 0;
    idle(2);

    // table vectors, expectations for the Latency=1 / MaxOutstanding=1 instance
    //          req addr          stl rst we waddr  wdata         gnt rv rdata          err busy
    vt[0]  = '{0, 32'h0,        0, 0, 1, 10'd5, 32'hDEADBEEF, 0, 0, 32'h0,         0, 0};
    vt[1]  = '{1, 32'h14,       0, 0, 0, 10'd0, 32'h0,        1, 0, 32'h0,         0, 0};
    vt[2]  = '{1, 32'h17,       0, 0, 0, 10'd0, 32'h0,        1, 1, 32'hDEADBEEF,  0, 1};
    vt[3]  = '{0, 32'h0,        0, 0, 0, 10'd0, 32'h0,        0, 1, 32'hDEADBEEF,  0, 1};
    vt[4]  = '{0, 32'h0,        0, 0, 0, 10'd0, 32'h0,        0, 0, 32'h0,         0, 0};
    vt[5]  = '{0, 32'h0,        0, 0, 1, 10'd2, 32'h11111111, 0, 0, 32'h0,         0, 0};
    vt[6]  = '{1, 32'h8,        0, 0, 1, 10'd2, 32'h22222222, 1, 0, 32'h0,         0, 0};
    vt[7]  = '{1, 32'h8,        0, 0, 0, 10'd0, 32'h0,        1, 1, 32'h11111111,  0, 1};
    vt[8]  = '{1, 32'h0,        1, 0, 0, 10'd0, 32'h0,        0, 1, 32'h22222222,  0, 1};
    vt[9]  = '{1, 32'h8,        1, 0, 0, 10'd0, 32'h0,        0, 0, 32'h0,         0, 0};
    vt[10] = '{1, 32'h8,        1, 0, 0, 10'd0, 32'h0,        0, 0, 32'h0,         0, 0};
    vt[11] = '{1, 32'h8,        1, 0, 0, 10'd0, 32'h0,        0, 0, 32'h0,         0, 0};
    vt[12] = '{1, 32'h8,        0, 0, 0, 10'd0, 32'h0,        1, 0, 32'h0,         0, 0};
    vt[13] = '{1, 32'h1000,     0, 0, 0, 10'd0, 32'h0,        1, 1, 32'h22222222,  0, 1};
    vt[14] = '{0, 32'h0,        0, 0, 0, 10'd0, 32'h0,        0, 1, 32'h0,         1, 1};
    vt[15] = '{1, 32'h4,        0, 1, 0, 10'd0, 32'h0,        0, 0, 32'h0,         0, 0};
    for (int r = 0; r < 16; r++) begin
      req = vt[r].req; addr = vt[r].addr; stall = vt[r].stall; rst = vt[r].rst;
      load_we = vt[r].we; load_addr = vt[r].waddr; load_wdata = vt[r].wdata;
      tick();
      chk($sformatf("vec%0d_gnt", r),    {31'b0, s_gnt[0]},  {31'b0, vt[r].e_gnt});
      chk($sformatf("vec%0d_rvalid", r), {31'b0, s_rv[0]},   {31'b0, vt[r].e_rv});
      chk($sformatf("vec%0d_rdata", r),  s_rd[0],            vt[r].e_rd);
      chk($sformatf("vec%0d_err", r),    {31'b0, s_err[0]},  {31'b0, vt[r].e_err});
      chk($sformatf("vec%0d_busy", r),   {31'b0, s_busy[0]}, {31'b0, vt[r].e_busy});
    end
    idle(6);

    // throttling: Latency=3, MaxOutstanding=2 -> grants 0,1,3 and rvalids 3,4,6
    begin
      logic eg7[7];
      logic ev7[7];
      eg7 = '{1, 1, 0, 1, 0, 0, 0};
      ev7 = '{0, 0, 0, 1, 1, 0, 1};
      fetch_list(1, 3, 32'h1000, 32'h1004, 32'h1008, 7);
      for (int c = 0; c < 7; c++) begin
        chk($sformatf("thr_gnt_c%0d", c), {31'b0, g_hist[c]}, {31'b0, eg7[c]});
        chk($sformatf("thr_rv_c%0d", c),  {31'b0, v_hist[c]}, {31'b0, ev7[c]});
      end
      chk("thr_count", rsp_d.size(), 3);
      if (rsp_d.size() == 3) begin
        for (int i = 0; i < 3; i++) chk($sformatf("thr_rdata%0d", i), rsp_d[i], mem_m[i]);
      end
    end
    idle(6);

    // out-of-range window on the BaseAddr=0x1000 instance
    fetch_list(1, 3, 32'h0FFC, 32'h2000, 32'h1FFC, 12);
    chk("oob_count", rsp_d.size(), 3);
    if (rsp_d.size() == 3) begin
      chk("oob_lo_err",   {31'b0, rsp_e[0]}, 32'h1);
      chk("oob_lo_rdata", rsp_d[0], 32'h0);
      chk("oob_hi_err",   {31'b0, rsp_e[1]}, 32'h1);
      chk("oob_hi_rdata", rsp_d[1], 32'h0);
      chk("top_err",      {31'b0, rsp_e[2]}, 32'h0);
      chk("top_rdata",    rsp_d[2], mem_m[1023]);
    end
    idle(6);

    // back-to-back with MaxOutstanding=1: slot freed by the retiring response
    begin
      int ng;
      ng = 0;
      for (int i = 0; i < 8; i++) begin
        req = 1; addr = 32'(i * 4);
        tick();
        if (s_gnt[0]) ng++;
      end
      req = 0;
      chk("b2b_grants", ng, 8);
    end
    idle(6);

    // reset with two requests in flight on the Latency=4 instance
    req = 1; addr = 32'h10; tick();
    chk("rst_g0", {31'b0, s_gnt[2]}, 32'h1);
    addr = 32'h14; tick();
    chk("rst_g1", {31'b0, s_gnt[2]}, 32'h1);
    req = 0; rst = 1; tick();
    rst = 0;
    begin
      int nrv;
      int nbusy;
      nrv = 0; nbusy = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (s_rv[2]) nrv++;
        if (s_busy[2]) nbusy++;
      end
      chk("rst_dropped_rv", nrv, 0);
      chk("rst_busy", nbusy, 0);
    end
    fetch_list(2, 1, 32'h10, 32'h0, 32'h0, 8);
    chk("rst_refetch_count", rsp_d.size(), 1);
    chk("rst_refetch_lat", {31'b0, v_hist[4]}, 32'h1);
    if (rsp_d.size() == 1) chk("rst_refetch_rdata", rsp_d[0], mem_m[4]);
    idle(6);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      req        = ($urandom_range(0, 3) != 0);
      addr       = $urandom_range(0, 32'h2FFF);
      stall      = ($urandom_range(0, 4) == 0);
      load_we    = ($urandom_range(0, 3) == 0);
      load_addr  = 10'($urandom_range(0, 1023));
      load_wdata = $urandom;
      rst        = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
